// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and constants for the HI/LO divide controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int DIV_WIDTH = 32;

  // LO value committed when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

`default_nettype wire

// File: rtl/div_hilo_ctrl_cond_negate.sv
// ============================================================================
// cond_negate : combinational conditional two's-complement negation
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);

  assign out = neg ? -in : in;

endmodule

`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
// ============================================================================
// div_hilo_ctrl : DIV/DIVU sequencing, sign handling and HI/LO commit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module div_hilo_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  input  logic [2*WIDTH-1:0] div_result,
  input  logic [WIDTH-1:0]   hi_in,
  input  logic [WIDTH-1:0]   lo_in,
  input  logic               hi_we,
  input  logic               lo_we,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES - 1);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_commit;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_a;
  logic [WIDTH-1:0] r_div_b;
  logic [WIDTH-1:0] r_dividend_raw;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_sa;
  logic             w_sb;
  logic             w_divisor_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_sa           = is_signed & dividend[WIDTH-1];
  assign w_sb           = is_signed & divisor[WIDTH-1];
  assign w_divisor_zero = (divisor == '0);

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (.in(dividend), .neg(w_sa), .out(w_a_mag));
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (.in(divisor),  .neg(w_sb), .out(w_b_mag));

  cond_negate #(.WIDTH(WIDTH)) u_fix_q (
    .in  (div_result[WIDTH-1:0]),
    .neg (r_neg_q),
    .out (w_quot_fix)
  );
  cond_negate #(.WIDTH(WIDTH)) u_fix_r (
    .in  (div_result[2*WIDTH-1:WIDTH]),
    .neg (r_neg_r),
    .out (w_rem_fix)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture and settle counter; div_a/div_b hold their value in IDLE
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt          <= '0;
      r_div_a        <= '0;
      r_div_b        <= '0;
      r_dividend_raw <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_zero         <= 1'b0;
    end else if (w_accept) begin
      r_cnt          <= w_divisor_zero ? '0 : c_cnt_load;
      r_div_a        <= w_a_mag;
      r_div_b        <= w_b_mag;
      r_dividend_raw <= dividend;
      r_neg_q        <= w_sa ^ w_sb;
      r_neg_r        <= w_sa;
      r_zero         <= w_divisor_zero;
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_dbz <= 1'b0;
      end
      if (w_commit) begin
        if (r_zero) begin
          r_hi  <= r_dividend_raw;
          r_lo  <= {WIDTH{DIV0_QUOTIENT[0]}};
          r_dbz <= 1'b1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end
      end else if (r_state == ST_IDLE) begin
        if (hi_we) r_hi <= hi_in;
        if (lo_we) r_lo <= lo_in;
      end
    end
  end

  assign div_a       = r_div_a;
  assign div_b       = r_div_b;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_div_hilo_ctrl.sv
// ============================================================================
// tb_div_hilo_ctrl : directed and random checks of div_hilo_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_div_hilo_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Unsigned combinational divider standing in for the external one
  assign div_result = (div_b == 32'd0) ? 64'd0 : {div_a % div_b, div_a / div_b};

  div_hilo_ctrl #(.WIDTH(32), .SETTLE_CYCLES(4)) dut (
    .clock       (clk),
    .clear       (clear),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .div_a       (div_a),
    .div_b       (div_b),
    .div_result  (div_result),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result from plain signed/unsigned arithmetic
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo,
                                output logic edz);
    longint sa, sb, q, r;
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (b == 32'd0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      elo = q[31:0];
      ehi = r[31:0];
      edz = 1'b0;
    end
  endfunction

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit inject);
    logic [31:0] ehi, elo, emag;
    logic        edz;
    int          nbusy;
    bit          seen;
    model(s, a, b, ehi, elo, edz);
    emag = (s && a[31]) ? (32'd0 - a) : a;
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    check("div_a_mag", {32'd0, div_a}, {32'd0, emag});
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      if (busy) begin
        nbusy++;
        if (inject && nbusy == 2) begin
          start = 1'b1; dividend = 32'd99; divisor = 32'd0;
          hi_we = 1'b1; hi_in = 32'h0000_AAAA;
        end else begin
          start = 1'b0; hi_we = 1'b0;
        end
        @(negedge clk);
      end else begin
        seen = 1'b1;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    check("busy_cycles", 64'(nbusy), (b == 32'd0) ? 64'd1 : 64'd4);
    check("done_pulse", {63'd0, done}, 64'd1);
    check("hi", {32'd0, hi}, {32'd0, ehi});
    check("lo", {32'd0, lo}, {32'd0, elo});
    check("div_by_zero", {63'd0, div_by_zero}, {63'd0, edz});
    @(negedge clk);
    check("done_single", {63'd0, done}, 64'd0);
    check("no_restart", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rs;
    logic [31:0] ra, rb;
    clear = 1'b0; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; hi_in = '0; lo_in = '0; hi_we = 1'b0; lo_we = 1'b0;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_div_a", {32'd0, div_a}, 64'd0);
    check("rst_div_b", {32'd0, div_b}, 64'd0);
    @(negedge clk);
    clear = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_div(1'b1, 32'd5, 32'd0, 1'b0);
    run_div(1'b0, 32'd9, 32'd3, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b0, 32'd20, 32'd6, 1'b1);

    @(negedge clk);
    lo_we = 1'b1; lo_in = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", {32'd0, lo}, 64'h1234);

    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if (k % 6 == 5) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, 1'b0);
    end

    // Reset in the second WAIT cycle, after a known non-zero HI/LO
    run_div(1'b0, 32'd50, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 clear = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    clear = 1'b1;
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_hilo_ctrl.md
# div_hilo_ctrl

Sequencing and sign-handling stage wrapped around the team's unsigned combinational divider. It accepts a DIV/DIVU request from the datapath and drives operand magnitudes to the divider. It holds them stable for a programmable settle window, then sign-corrects the divider's {remainder, quotient} result and commits it to the HI/LO register pair. It also exposes busy/done handshaking to the control unit and handles MTHI/MTLO writes.

## Interface
- `WIDTH`, 32: operand width; the divider result is 2*WIDTH.
- `SETTLE_CYCLES`, 4: cycles the divider operands are held before the result is sampled; must be ≥1.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a divide; sampled only in IDLE.
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `dividend`  in  WIDTH  numerator, sampled with `start`.
- `divisor`  in  WIDTH  denominator, sampled with `start`.
- `div_a`  out  WIDTH  registered magnitude to divider dividend input.
- `div_b`  out  WIDTH  registered magnitude to divider divisor input.
- `div_result`  in  2*WIDTH  divider output: remainder in [2W-1:W], quotient in [W-1:0].
- `hi_in`, `lo_in`  in  WIDTH  MTHI/MTLO data.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write enables.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after HI/LO commit.
- `div_by_zero`  out  1  set with `done` when divisor was 0; held until next accepted `start`.
- `hi`, `lo`  out  WIDTH  architectural HI (remainder) and LO (quotient).

## Operation
- States: IDLE, WAIT.
- IDLE:
  - `start=1` at edge E0 → latch `div_a`/`div_b`.
    - When `is_signed` and the operand MSB is set, the latched value is its two's-complement negation; otherwise it is the raw operand.
  - At the same edge, latch the sign flags: `neg_q = sa^sb`, `neg_r = sa`. Both are 0 for DIVU.
  - At the same edge: clear `div_by_zero`, `cnt <= SETTLE_CYCLES-1`, go to WAIT.
- WAIT, `cnt≠0` → `cnt--`.
- WAIT, `cnt==0` → commit, `done<=1`, go to IDLE.
  - Committed LO = quotient, negated if `neg_q`.
  - Committed HI = remainder, negated if `neg_r`.
- Divide by zero (latched divisor = 0):
  - `cnt` is loaded with 0 regardless of the parameter.
  - Commit: HI = original dividend (raw, not magnitude); LO = all ones; `div_by_zero<=1`.
- Arithmetic wraps modulo 2^WIDTH.
  - Signed `0x80000000 / 0xFFFFFFFF` gives LO = `0x80000000`, HI = 0. No trap.
- `start` while busy: ignored, not queued.
- `hi_we`/`lo_we`:
  - In IDLE, write HI/LO on the edge.
  - While busy, ignored.
  - A divide commit and an MTHI/MTLO write can never coincide, because the commit edge is inside busy.
- `done` is asserted in the cycle right after commit. If `start` is asserted in that same cycle, it is accepted.

## Timing
- Reset (`clear=0`, asynchronous): state=IDLE, `cnt`=0, `div_a`=`div_b`=0, `hi`=`lo`=0, `busy`=0, `done`=0, `div_by_zero`=0.
- Reset mid-operation abandons the divide; HI/LO read 0.
- Latency:
  - `start` sampled at E0; HI/LO updated at E(SETTLE_CYCLES); `done` high for the cycle following that edge.
  - Divide by zero: HI/LO at E1.
- `busy` is high from after E0 through the commit edge: SETTLE_CYCLES cycles, or 1 for divide by zero.
- `div_a`/`div_b` are stable for the whole WAIT window; the divider path is a multicycle path of SETTLE_CYCLES cycles.
- `div_a`/`div_b` retain their last value in IDLE.

## Structure
- Package `div_pkg` holds:
  - state enum (IDLE, WAIT);
  - default `WIDTH`;
  - constant `DIV0_QUOTIENT` (all ones).
- One sub-module, `cond_negate` (WIDTH-parameterised, combinational): `out = neg ? -in : in`.
  - Four instances: two for operand magnitudes, two for result correction.
- The divider itself stays outside; the top level wires it to `div_a`/`div_b`/`div_result`.

## Test plan
Bench instantiates the existing divider between `div_a`/`div_b` and `div_result`; SETTLE_CYCLES=4.
- DIVU 100/7 → `done` 4 cycles after `start` edge; LO=14, HI=2, `div_by_zero`=0, `busy` high exactly 4 cycles.
- DIV 0xFFFFFFF9(-7)/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands → LO=0x7FFFFFFC, HI=1.
- DIV 5/0 → after 1 cycle: HI=5, LO=0xFFFFFFFF, `div_by_zero`=1. Next DIVU 9/3 clears it: LO=3, HI=0.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- `start` and `hi_we` (`hi_in`=0xAAAA) pulsed during WAIT of a 20/6 divide → no second divide; HI=2, LO=3.
- In IDLE, `lo_we` with 0x1234 → LO=0x1234 next cycle.
- `clear` dropped in the 2nd WAIT cycle → `busy`/`done`/HI/LO=0 immediately; a new `start` after release completes normally.
